// File: rtl/redmule_tile_pkg.sv
// Shared OBI/HCI data-port types for the core-to-cluster path, plus the bridge tag entry.
// Latency: none (types only). Backpressure: none. The tag entry carries an err bit only under OBI2HCI_ERR_EN.
package redmule_tile_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;
    localparam int unsigned ObiIdWidth   = 1;
    localparam int unsigned HciUserWidth = 1;

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [ObiDataWidth-1:0] wdata;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiIdWidth-1:0]   aid;
    } core_obi_a_t;

    typedef struct packed {
        logic        req;
        core_obi_a_t a;
        logic        rready;
    } core_obi_data_req_t;

    typedef struct packed {
        logic       exokay;
        logic [0:0] ruser;
        logic [0:0] rchk;
    } core_obi_r_optional_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
        core_obi_r_optional_t    r_optional;
    } core_obi_r_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        core_obi_r_t r;
    } core_obi_data_rsp_t;

    typedef struct packed {
        logic                    req;
        logic [ObiAddrWidth-1:0] add;
        logic                    wen;
        logic [ObiDataWidth-1:0] data;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiBeWidth-1:0]   boffs;
        logic                    lrdy;
        logic [HciUserWidth-1:0] user;
    } core_hci_data_req_t;

    typedef struct packed {
        logic                    gnt;
        logic                    r_valid;
        logic [ObiDataWidth-1:0] r_data;
    } core_hci_data_rsp_t;

`ifdef OBI2HCI_ERR_EN
    typedef struct packed {
        logic [ObiIdWidth-1:0] rid;
        logic                  err;
    } tag_entry_t;
`else
    typedef struct packed {
        logic [ObiIdWidth-1:0] rid;
    } tag_entry_t;
`endif

    // Misaligned word accesses and empty byte masks are answered locally with an error.
    function automatic logic obi_local_err(input logic [ObiAddrWidth-1:0] addr,
                                           input logic [ObiBeWidth-1:0]   be);
        return (addr[1:0] != 2'b00) || (be == '0);
    endfunction

endpackage

// File: rtl/obi2hci_tag_fifo.sv
// In-order tag store for granted-but-unanswered bridge transactions.
// Latency: push visible at head one cycle later. Backpressure: full/empty from registered occupancy; push at full and pop at empty are ignored.
module obi2hci_tag_fifo
    import redmule_tile_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  tag_entry_t push_dat_i,
    input  logic       pop_i,
    output tag_entry_t head_dat_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    tag_entry_t [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o     = (cnt_q == DepthCnt);
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/obi2hci_bridge.sv
// OBI data port to HCI bridge; OBI2HCI_ERR_EN adds local error responses for misaligned / empty-mask requests.
// Latency: zero-cycle request/grant path, responses follow HCI r_valid. Backpressure: requests stall at MaxOutstanding tags; lrdy follows rready.
module obi2hci_bridge
    import redmule_tile_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned IdWidth        = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  core_obi_data_req_t obi_req_i,
    output core_obi_data_rsp_t obi_rsp_o,
    output core_hci_data_req_t hci_req_o,
    input  core_hci_data_rsp_t hci_rsp_i
);

    if (IdWidth != ObiIdWidth) begin : g_id_width_chk
        $error("IdWidth must equal redmule_tile_pkg::ObiIdWidth");
    end
    if ((MaxOutstanding < 1) || ((MaxOutstanding & (MaxOutstanding - 1)) != 0)) begin : g_depth_chk
        $error("MaxOutstanding must be a power of two and at least 1");
    end

    tag_entry_t push_tag;
    tag_entry_t head_tag;
    logic       tag_full;
    logic       tag_empty;
    logic       tag_push;
    logic       tag_pop;
    logic       loc_err;
    logic       head_err;
    logic       fwd_req;

`ifdef OBI2HCI_ERR_EN
    assign loc_err  = obi_local_err(obi_req_i.a.addr, obi_req_i.a.be);
    assign head_err = head_tag.err;
`else
    assign loc_err  = 1'b0;
    assign head_err = 1'b0;
`endif

    always_comb begin
        push_tag     = '0;
        push_tag.rid = obi_req_i.a.aid;
`ifdef OBI2HCI_ERR_EN
        push_tag.err = loc_err;
`endif
    end

    always_comb begin
        hci_req_o = '0;
        obi_rsp_o = '0;

        // Full is registered, so a same-cycle pop never opens a slot for this request.
        fwd_req         = obi_req_i.req && !tag_full && !loc_err && !rst_i;
        hci_req_o.req   = fwd_req;
        hci_req_o.add   = obi_req_i.a.addr;
        hci_req_o.wen   = !obi_req_i.a.we;
        hci_req_o.data  = obi_req_i.a.wdata;
        hci_req_o.be    = obi_req_i.a.be;
        hci_req_o.lrdy  = !rst_i && !tag_empty && !head_err && obi_req_i.rready;

        obi_rsp_o.gnt   = (fwd_req && hci_rsp_i.gnt) ||
                          (!rst_i && obi_req_i.req && loc_err && !tag_full);

        obi_rsp_o.r.rid = head_tag.rid;
        if (head_err) begin
            // Locally errored entries answer on their own, independent of HCI.
            obi_rsp_o.rvalid  = !rst_i && !tag_empty;
            obi_rsp_o.r.rdata = '0;
            obi_rsp_o.r.err   = 1'b1;
        end else begin
            obi_rsp_o.rvalid  = !rst_i && !tag_empty && hci_rsp_i.r_valid;
            obi_rsp_o.r.rdata = hci_rsp_i.r_data;
            obi_rsp_o.r.err   = 1'b0;
        end

        tag_push = obi_rsp_o.gnt;
        tag_pop  = obi_rsp_o.rvalid && obi_req_i.rready;
    end

    obi2hci_tag_fifo #(
        .Depth (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (tag_push),
        .push_dat_i (push_tag),
        .pop_i      (tag_pop),
        .head_dat_o (head_tag),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    // An HCI response with nothing outstanding is a protocol violation; it is dropped.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(hci_rsp_i.r_valid && tag_empty));

endmodule

// File: tb/tb_obi2hci_bridge.sv
// Directed bench for obi2hci_bridge with hand-computed expectations; error-path vectors depend on OBI2HCI_ERR_EN.
module tb_obi2hci_bridge;
    import redmule_tile_pkg::*;

    logic               clk_i;
    logic               rst_i;
    core_obi_data_req_t obi_req;
    core_obi_data_rsp_t obi_rsp;
    core_hci_data_req_t hci_req;
    core_hci_data_rsp_t hci_rsp;

    int n_checks = 0;
    int n_fail   = 0;

    obi2hci_bridge #(
        .MaxOutstanding (2),
        .IdWidth        (1)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .obi_req_i (obi_req),
        .obi_rsp_o (obi_rsp),
        .hci_req_o (hci_req),
        .hci_rsp_i (hci_rsp)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input logic aid);
        obi_req.req     = v;
        obi_req.a.we    = we;
        obi_req.a.addr  = addr;
        obi_req.a.wdata = wdata;
        obi_req.a.be    = be;
        obi_req.a.aid   = aid;
    endtask

    task automatic set_hci(input logic gnt, input logic rv, input logic [31:0] rdata);
        hci_rsp.gnt     = gnt;
        hci_rsp.r_valid = rv;
        hci_rsp.r_data  = rdata;
    endtask

    initial begin
        rst_i   = 1'b1;
        obi_req = '0;
        hci_rsp = '0;
        obi_req.rready = 1'b1;

        // Reset: everything gated even with a pending request and HCI grant.
        tick(); tick();
        set_req(1, 0, 32'h100, 0, 4'hF, 1);
        set_hci(1, 0, 0);
        settle();
        check_eq("rst_gnt", obi_rsp.gnt, 0);
        check_eq("rst_hreq", hci_req.req, 0);
        check_eq("rst_rvalid", obi_rsp.rvalid, 0);
        check_eq("rst_lrdy", hci_req.lrdy, 0);
        tick();
        rst_i = 1'b0;
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 0, 0);
        settle();
        check_eq("post_rst_rvalid", obi_rsp.rvalid, 0);
        check_eq("post_rst_lrdy", hci_req.lrdy, 0);

        // Single read, same-cycle grant, response next cycle.
        tick();
        set_req(1, 0, 32'h100, 0, 4'hF, 1);
        set_hci(1, 0, 0);
        settle();
        check_eq("rd_hreq", hci_req.req, 1);
        check_eq("rd_wen", hci_req.wen, 1);
        check_eq("rd_add", hci_req.add, 32'h100);
        check_eq("rd_be", hci_req.be, 4'hF);
        check_eq("rd_gnt", obi_rsp.gnt, 1);
        check_eq("rd_rvalid_early", obi_rsp.rvalid, 0);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'hCAFE);
        settle();
        check_eq("rd_rvalid", obi_rsp.rvalid, 1);
        check_eq("rd_rdata", obi_rsp.r.rdata, 32'hCAFE);
        check_eq("rd_rid", obi_rsp.r.rid, 1);
        check_eq("rd_err", obi_rsp.r.err, 0);
        check_eq("rd_lrdy", hci_req.lrdy, 1);
        check_eq("rd_ropt", obi_rsp.r.r_optional, 0);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("rd_drained_lrdy", hci_req.lrdy, 0);

        // Back-to-back: third request stalls at full, granted the cycle after the first pop.
        tick();
        set_req(1, 0, 32'h200, 0, 4'hF, 0);
        set_hci(1, 0, 0);
        settle();
        check_eq("b2b_gnt0", obi_rsp.gnt, 1);
        tick();
        set_req(1, 0, 32'h204, 0, 4'hF, 1);
        settle();
        check_eq("b2b_gnt1", obi_rsp.gnt, 1);
        tick();
        set_req(1, 0, 32'h208, 0, 4'hF, 0);
        settle();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                tick(); settle();
            end
            check_eq("b2b_full_hreq", hci_req.req, 0);
            check_eq("b2b_full_gnt", obi_rsp.gnt, 0);
        end
        tick();
        set_hci(1, 1, 32'h11);
        settle();
        check_eq("b2b_r0_rvalid", obi_rsp.rvalid, 1);
        check_eq("b2b_r0_rid", obi_rsp.r.rid, 0);
        check_eq("b2b_r0_rdata", obi_rsp.r.rdata, 32'h11);
        check_eq("b2b_popcyc_hreq", hci_req.req, 0);
        check_eq("b2b_popcyc_gnt", obi_rsp.gnt, 0);
        tick();
        set_hci(1, 0, 0);
        settle();
        check_eq("b2b_after_hreq", hci_req.req, 1);
        check_eq("b2b_after_gnt", obi_rsp.gnt, 1);
        check_eq("b2b_after_rvalid", obi_rsp.rvalid, 0);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'h22);
        settle();
        check_eq("b2b_r1_rid", obi_rsp.r.rid, 1);
        check_eq("b2b_r1_rdata", obi_rsp.r.rdata, 32'h22);
        tick();
        set_hci(0, 1, 32'h33);
        settle();
        check_eq("b2b_r2_rid", obi_rsp.r.rid, 0);
        check_eq("b2b_r2_rdata", obi_rsp.r.rdata, 32'h33);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("b2b_drained_lrdy", hci_req.lrdy, 0);

        // Write held off by HCI for three cycles.
        tick();
        set_req(1, 1, 32'h300, 32'h1234, 4'hF, 1);
        set_hci(0, 0, 0);
        settle();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick(); settle();
            end
            check_eq("wr_wait_hreq", hci_req.req, 1);
            check_eq("wr_wait_wen", hci_req.wen, 0);
            check_eq("wr_wait_data", hci_req.data, 32'h1234);
            check_eq("wr_wait_gnt", obi_rsp.gnt, 0);
            check_eq("wr_wait_lrdy", hci_req.lrdy, 0);
        end
        tick();
        set_hci(1, 0, 0);
        settle();
        check_eq("wr_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 0, 0);
        settle();
        check_eq("wr_one_entry_lrdy", hci_req.lrdy, 1);
        tick();
        set_hci(0, 1, 32'h0);
        settle();
        check_eq("wr_rvalid", obi_rsp.rvalid, 1);
        check_eq("wr_rid", obi_rsp.r.rid, 1);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("wr_single_push", hci_req.lrdy, 0);

        // rready backpressure holds the response.
        tick();
        set_req(1, 0, 32'h400, 0, 4'hF, 0);
        set_hci(1, 0, 0);
        settle();
        check_eq("bp_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'hBEEF);
        obi_req.rready = 1'b0;
        settle();
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                tick(); settle();
            end
            check_eq("bp_hold_lrdy", hci_req.lrdy, 0);
            check_eq("bp_hold_rvalid", obi_rsp.rvalid, 1);
            check_eq("bp_hold_rdata", obi_rsp.r.rdata, 32'hBEEF);
        end
        tick();
        obi_req.rready = 1'b1;
        settle();
        check_eq("bp_rel_lrdy", hci_req.lrdy, 1);
        check_eq("bp_rel_rvalid", obi_rsp.rvalid, 1);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("bp_popped_lrdy", hci_req.lrdy, 0);

        // Reset with two outstanding tags, then a clean read.
        tick();
        set_req(1, 0, 32'h500, 0, 4'hF, 1);
        set_hci(1, 0, 0);
        settle();
        check_eq("mr_gnt0", obi_rsp.gnt, 1);
        tick();
        set_req(1, 0, 32'h504, 0, 4'hF, 1);
        settle();
        check_eq("mr_gnt1", obi_rsp.gnt, 1);
        tick();
        rst_i = 1'b1;
        set_req(1, 0, 32'h508, 0, 4'hF, 0);
        settle();
        check_eq("mr_rst_hreq", hci_req.req, 0);
        check_eq("mr_rst_gnt", obi_rsp.gnt, 0);
        check_eq("mr_rst_lrdy", hci_req.lrdy, 0);
        tick();
        rst_i = 1'b0;
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 0, 0);
        settle();
        check_eq("mr_empty_rvalid", obi_rsp.rvalid, 0);
        check_eq("mr_empty_lrdy", hci_req.lrdy, 0);
        tick();
        set_req(1, 0, 32'h600, 0, 4'hF, 0);
        set_hci(1, 0, 0);
        settle();
        check_eq("mr_new_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'h600D);
        settle();
        check_eq("mr_new_rvalid", obi_rsp.rvalid, 1);
        check_eq("mr_new_rid", obi_rsp.r.rid, 0);
        check_eq("mr_new_rdata", obi_rsp.r.rdata, 32'h600D);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("mr_drained_lrdy", hci_req.lrdy, 0);

`ifdef OBI2HCI_ERR_EN
        // Misaligned request between two good reads answers locally, in order.
        tick();
        set_req(1, 0, 32'h700, 0, 4'hF, 0);
        set_hci(1, 0, 0);
        settle();
        check_eq("le_a_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(1, 0, 32'h702, 0, 4'hF, 1);
        settle();
        check_eq("le_b_hreq", hci_req.req, 0);
        check_eq("le_b_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'hAAAA);
        settle();
        check_eq("le_ra_rvalid", obi_rsp.rvalid, 1);
        check_eq("le_ra_err", obi_rsp.r.err, 0);
        check_eq("le_ra_rdata", obi_rsp.r.rdata, 32'hAAAA);
        tick();
        set_req(1, 0, 32'h70C, 0, 4'hF, 0);
        set_hci(1, 0, 0);
        settle();
        check_eq("le_rb_rvalid", obi_rsp.rvalid, 1);
        check_eq("le_rb_err", obi_rsp.r.err, 1);
        check_eq("le_rb_rid", obi_rsp.r.rid, 1);
        check_eq("le_rb_rdata", obi_rsp.r.rdata, 0);
        check_eq("le_rb_lrdy", hci_req.lrdy, 0);
        check_eq("le_c_hreq", hci_req.req, 1);
        check_eq("le_c_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'hBBBB);
        settle();
        check_eq("le_rc_rid", obi_rsp.r.rid, 0);
        check_eq("le_rc_err", obi_rsp.r.err, 0);
        check_eq("le_rc_rdata", obi_rsp.r.rdata, 32'hBBBB);
        tick();
        set_req(1, 0, 32'h710, 0, 4'h0, 1);
        set_hci(1, 0, 0);
        settle();
        check_eq("le_be0_hreq", hci_req.req, 0);
        check_eq("le_be0_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 0, 0);
        settle();
        check_eq("le_be0_rvalid", obi_rsp.rvalid, 1);
        check_eq("le_be0_err", obi_rsp.r.err, 1);
        tick();
        settle();
        check_eq("le_drained_rvalid", obi_rsp.rvalid, 0);
`else
        // Without local errors, a misaligned address is forwarded like any other.
        tick();
        set_req(1, 0, 32'h102, 0, 4'hF, 1);
        set_hci(1, 0, 0);
        settle();
        check_eq("fw_hreq", hci_req.req, 1);
        check_eq("fw_add", hci_req.add, 32'h102);
        check_eq("fw_gnt", obi_rsp.gnt, 1);
        tick();
        set_req(0, 0, 0, 0, 4'hF, 0);
        set_hci(0, 1, 32'h55);
        settle();
        check_eq("fw_rvalid", obi_rsp.rvalid, 1);
        check_eq("fw_err", obi_rsp.r.err, 0);
        check_eq("fw_rdata", obi_rsp.r.rdata, 32'h55);
        tick();
        set_hci(0, 0, 0);
        settle();
        check_eq("fw_drained_lrdy", hci_req.lrdy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
